// File: rtl/control_sequencer_if.sv
// Control/status bundle between the hardwired sequencer and the datapath it steers.
// The sequencer takes the master modport; the datapath (or a testbench) takes the slave modport.
interface control_sequencer_if;
   logic [31:0] ir_out;
   logic        con_ff;
   logic        mem_ready;
   logic        gra, grb, grc;
   logic        rin, rout, baout;
   logic        pc_out, pc_in, inc_pc;
   logic        mar_in, mdr_in, mdr_out;
   logic        read, write;
   logic        ir_in, y_in, z_in, zlo_out, c_out, con_in;
   logic [3:0]  alu_op;
   logic        run;
   logic        illegal;

   modport master (
      input  ir_out, con_ff, mem_ready,
      output gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc,
             mar_in, mdr_in, mdr_out, read, write,
             ir_in, y_in, z_in, zlo_out, c_out, con_in, alu_op, run, illegal
   );

   modport slave (
      output ir_out, con_ff, mem_ready,
      input  gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc,
             mar_in, mdr_in, mdr_out, read, write,
             ir_in, y_in, z_in, zlo_out, c_out, con_in, alu_op, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit, one control step per clock.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and latch illegal.
module control_sequencer #(
   parameter logic [3:0] ALU_ADD = 4'b0011,
   parameter logic [3:0] ALU_SUB = 4'b0100,
   parameter logic [3:0] ALU_AND = 4'b0101,
   parameter logic [3:0] ALU_OR  = 4'b0110
) (
   input logic                  clk,
   input logic                  reset,
   control_sequencer_if.master  bus_io
);

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpAnd  = 5'b00101;
   localparam logic [4:0] OpOr   = 5'b00110;
   localparam logic [4:0] OpAddi = 5'b01100;
   localparam logic [4:0] OpAndi = 5'b01101;
   localparam logic [4:0] OpOri  = 5'b01110;
   localparam logic [4:0] OpBr   = 5'b10010;
   localparam logic [4:0] OpJr   = 5'b10011;
   localparam logic [4:0] OpNop  = 5'b11010;
   localparam logic [4:0] OpHalt = 5'b11011;

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
   } state_e;

   state_e     state_q, state_d;
   logic       run_q;
   logic [4:0] op;
   logic       is_reg_alu, is_imm_alu, is_mem;
   logic [3:0] alu_sel;
   logic       unused_ir;

   assign op        = bus_io.ir_out[31:27];
   assign unused_ir = ^bus_io.ir_out[26:0];

   assign is_reg_alu = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);
   assign is_imm_alu = (op == OpAddi) || (op == OpAndi) || (op == OpOri);
   assign is_mem     = (op == OpLd) || (op == OpLdi) || (op == OpSt);

   always_comb begin
      alu_sel = ALU_ADD;
      case (op)
         OpSub:          alu_sel = ALU_SUB;
         OpAnd, OpAndi:  alu_sel = ALU_AND;
         OpOr, OpOri:    alu_sel = ALU_OR;
         default:        alu_sel = ALU_ADD;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   logic op_defined;

   assign op_defined = is_reg_alu || is_imm_alu || is_mem || (op == OpBr) || (op == OpJr) ||
                       (op == OpNop) || (op == OpHalt);
`endif

   always_comb begin
      state_d        = state_q;
      bus_io.gra     = 1'b0;
      bus_io.grb     = 1'b0;
      bus_io.grc     = 1'b0;
      bus_io.rin     = 1'b0;
      bus_io.rout    = 1'b0;
      bus_io.baout   = 1'b0;
      bus_io.pc_out  = 1'b0;
      bus_io.pc_in   = 1'b0;
      bus_io.inc_pc  = 1'b0;
      bus_io.mar_in  = 1'b0;
      bus_io.mdr_in  = 1'b0;
      bus_io.mdr_out = 1'b0;
      bus_io.read    = 1'b0;
      bus_io.write   = 1'b0;
      bus_io.ir_in   = 1'b0;
      bus_io.y_in    = 1'b0;
      bus_io.z_in    = 1'b0;
      bus_io.zlo_out = 1'b0;
      bus_io.c_out   = 1'b0;
      bus_io.con_in  = 1'b0;
      bus_io.alu_op  = 4'b0000;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d      = illegal_q;
`endif
      unique case (state_q)
         StIdle: state_d = StT0;
         StT0: begin
            bus_io.pc_out = 1'b1;
            bus_io.mar_in = 1'b1;
            bus_io.inc_pc = 1'b1;
            bus_io.z_in   = 1'b1;
            state_d       = StT1;
         end
         StT1: begin
            bus_io.zlo_out = 1'b1;
            bus_io.pc_in   = 1'b1;
            bus_io.read    = 1'b1;
            bus_io.mdr_in  = 1'b1;
            if (bus_io.mem_ready) state_d = StT2;
         end
         StT2: begin
            bus_io.mdr_out = 1'b1;
            bus_io.ir_in   = 1'b1;
            state_d        = StT3;
         end
         StT3: begin
            state_d = StT4;
            if (is_reg_alu || is_imm_alu) begin
               bus_io.grb  = 1'b1;
               bus_io.rout = 1'b1;
               bus_io.y_in = 1'b1;
            end else if (is_mem) begin
               bus_io.grb   = 1'b1;
               bus_io.baout = 1'b1;
               bus_io.y_in  = 1'b1;
            end else if (op == OpBr) begin
               bus_io.gra    = 1'b1;
               bus_io.rout   = 1'b1;
               bus_io.con_in = 1'b1;
            end else if (op == OpJr) begin
               bus_io.gra   = 1'b1;
               bus_io.rout  = 1'b1;
               bus_io.pc_in = 1'b1;
               state_d      = StT0;
            end else if (op == OpHalt) begin
               state_d = StHalt;
            end else begin
               state_d = StT0;
`ifdef CTRL_ILLEGAL_TRAP_EN
               if (!op_defined) begin
                  state_d   = StHalt;
                  illegal_d = 1'b1;
               end
`endif
            end
         end
         StT4: begin
            state_d = StT5;
            if (op == OpBr) begin
               bus_io.grb   = 1'b1;
               bus_io.rout  = 1'b1;
               bus_io.pc_in = bus_io.con_ff;
               state_d      = StT0;
            end else if (is_reg_alu) begin
               bus_io.grc    = 1'b1;
               bus_io.rout   = 1'b1;
               bus_io.z_in   = 1'b1;
               bus_io.alu_op = alu_sel;
            end else begin
               // Immediates and load/store address offsets both come from the C field.
               bus_io.c_out  = 1'b1;
               bus_io.z_in   = 1'b1;
               bus_io.alu_op = is_mem ? ALU_ADD : alu_sel;
            end
         end
         StT5: begin
            bus_io.zlo_out = 1'b1;
            if ((op == OpLd) || (op == OpSt)) begin
               bus_io.mar_in = 1'b1;
               state_d       = StT6;
            end else begin
               bus_io.gra = 1'b1;
               bus_io.rin = 1'b1;
               state_d    = StT0;
            end
         end
         StT6: begin
            if (op == OpSt) begin
               bus_io.gra    = 1'b1;
               bus_io.rout   = 1'b1;
               bus_io.mdr_in = 1'b1;
               state_d       = StT7;
            end else begin
               bus_io.read   = 1'b1;
               bus_io.mdr_in = 1'b1;
               if (bus_io.mem_ready) state_d = StT7;
            end
         end
         StT7: begin
            if (op == OpSt) begin
               bus_io.write = 1'b1;
               if (bus_io.mem_ready) state_d = StT0;
            end else begin
               bus_io.mdr_out = 1'b1;
               bus_io.gra     = 1'b1;
               bus_io.rin     = 1'b1;
               state_d        = StT0;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // Registered from next state so run lines up with the step it describes.
         run_q   <= (state_d != StIdle) && (state_d != StHalt);
      end
   end

   assign bus_io.run = run_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign bus_io.illegal = illegal_q;
`else
   assign bus_io.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: expected strobe vectors are queued per
// instruction and popped one per clock, compared on the falling edge.
module tb_control_sequencer;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   localparam logic [25:0] Gra    = 26'd1 << 25;
   localparam logic [25:0] Grb    = 26'd1 << 24;
   localparam logic [25:0] Grc    = 26'd1 << 23;
   localparam logic [25:0] Rin    = 26'd1 << 22;
   localparam logic [25:0] Rout   = 26'd1 << 21;
   localparam logic [25:0] Baout  = 26'd1 << 20;
   localparam logic [25:0] PcOut  = 26'd1 << 19;
   localparam logic [25:0] PcIn   = 26'd1 << 18;
   localparam logic [25:0] IncPc  = 26'd1 << 17;
   localparam logic [25:0] MarIn  = 26'd1 << 16;
   localparam logic [25:0] MdrIn  = 26'd1 << 15;
   localparam logic [25:0] MdrOut = 26'd1 << 14;
   localparam logic [25:0] Read   = 26'd1 << 13;
   localparam logic [25:0] Write  = 26'd1 << 12;
   localparam logic [25:0] IrIn   = 26'd1 << 11;
   localparam logic [25:0] YIn    = 26'd1 << 10;
   localparam logic [25:0] ZIn    = 26'd1 << 9;
   localparam logic [25:0] ZloOut = 26'd1 << 8;
   localparam logic [25:0] COut   = 26'd1 << 7;
   localparam logic [25:0] ConIn  = 26'd1 << 6;
   localparam logic [25:0] AAdd   = 26'd3 << 2;
   localparam logic [25:0] AAnd   = 26'd5 << 2;
   localparam logic [25:0] Run    = 26'd1 << 1;
   localparam logic [25:0] Ill    = 26'd1;

   logic [25:0] obs;
   assign obs = {bus.gra, bus.grb, bus.grc, bus.rin, bus.rout, bus.baout, bus.pc_out,
                 bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in, bus.mdr_out, bus.read,
                 bus.write, bus.ir_in, bus.y_in, bus.z_in, bus.zlo_out, bus.c_out,
                 bus.con_in, bus.alu_op, bus.run, bus.illegal};

   typedef struct packed {
      logic        mr;
      logic [25:0] exp;
   } step_t;

   step_t sb_q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string tag, input logic [25:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic mr, input logic [25:0] exp);
      step_t s;
      s.mr  = mr;
      s.exp = exp;
      sb_q.push_back(s);
   endtask

   task automatic push_fetch();
      push(1'b1, PcOut | MarIn | IncPc | ZIn | Run);
      push(1'b1, ZloOut | PcIn | Read | MdrIn | Run);
      push(1'b1, MdrOut | IrIn | Run);
   endtask

   task automatic push_addr_calc();
      push(1'b1, Grb | Baout | YIn | Run);
      push(1'b1, COut | ZIn | AAdd | Run);
   endtask

   // One popped entry per clock: apply its mem_ready, then compare mid-cycle.
   task automatic drain(input string tag);
      step_t s;
      int    n = 0;
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         bus.mem_ready = s.mr;
         #1;
         check($sformatf("%s[%0d]", tag, n), s.exp);
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.ir_out    = 32'h0;
      bus.con_ff    = 1'b0;
      bus.mem_ready = 1'b0;

      @(negedge clk);
      repeat (3) push(1'b0, 26'd0);
      drain("reset_hold");

      reset      = 1'b0;
      bus.ir_out = 32'h1989_0000;
      push(1'b0, 26'd0);
      push_fetch();
      push(1'b1, Grb | Rout | YIn | Run);
      push(1'b1, Grc | Rout | ZIn | AAdd | Run);
      push(1'b1, ZloOut | Gra | Rin | Run);
      drain("add");

      bus.ir_out = {5'b01101, 27'd0};
      push_fetch();
      push(1'b1, Grb | Rout | YIn | Run);
      push(1'b1, COut | ZIn | AAnd | Run);
      push(1'b1, ZloOut | Gra | Rin | Run);
      drain("andi");

      bus.ir_out = {5'b00000, 27'd0};
      push_fetch();
      push_addr_calc();
      push(1'b1, ZloOut | MarIn | Run);
      repeat (4) push(1'b0, Read | MdrIn | Run);
      push(1'b1, Read | MdrIn | Run);
      push(1'b1, MdrOut | Gra | Rin | Run);
      drain("ld_wait");

      bus.ir_out = {5'b00001, 27'd0};
      push_fetch();
      push_addr_calc();
      push(1'b1, ZloOut | Gra | Rin | Run);
      drain("ldi");

      bus.ir_out = {5'b10010, 27'd0};
      bus.con_ff = 1'b0;
      push_fetch();
      push(1'b1, Gra | Rout | ConIn | Run);
      push(1'b1, Grb | Rout | Run);
      drain("br_nt");

      bus.con_ff = 1'b1;
      push_fetch();
      push(1'b1, Gra | Rout | ConIn | Run);
      push(1'b1, Grb | Rout | PcIn | Run);
      drain("br_t");

      bus.ir_out = {5'b10011, 27'd0};
      push_fetch();
      push(1'b1, Gra | Rout | PcIn | Run);
      drain("jr");

      bus.ir_out = {5'b11010, 27'd0};
      push_fetch();
      push(1'b1, Run);
      drain("nop");

      bus.ir_out = {5'b00010, 27'd0};
      push_fetch();
      push_addr_calc();
      push(1'b1, ZloOut | MarIn | Run);
      push(1'b1, Gra | Rout | MdrIn | Run);
      push(1'b0, Write | Run);
      push(1'b0, Write | Run);
      drain("st_wait");

      // Still in the T7 write wait: reset must clear everything without a clock edge.
      bus.mem_ready = 1'b0;
      #2 reset = 1'b1;
      #1 check("st_async_reset", 26'd0);
      @(negedge clk);
      reset = 1'b0;

      bus.ir_out = {5'b11011, 27'd0};
      push(1'b0, 26'd0);
      push_fetch();
      push(1'b1, Run);
      repeat (20) push(1'b1, 26'd0);
      drain("halt");

      reset = 1'b1;
      #1 check("halt_reset", 26'd0);
      @(negedge clk);
      reset = 1'b0;

      bus.ir_out = {5'b11111, 27'd0};
      push(1'b0, 26'd0);
      push_fetch();
      push(1'b1, Run);
`ifdef CTRL_ILLEGAL_TRAP_EN
      repeat (3) push(1'b1, Ill);
`else
      push(1'b1, PcOut | MarIn | IncPc | ZIn | Run);
`endif
      drain("undef_op");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
